pipe_control: RTL and testbench

Pipelined successor to the single-cycle opcode decoder for the mips32 core. Decodes the ID-stage instruction, carries the control word and destination register through registered EX/MEM/WB stages, and detects hazards. On a hazard it stalls, inserts a bubble, flushes after a taken branch, freezes the pipe on data-memory wait, and drives the EX forwarding selects. It sits between the IF/ID register and the datapath stage registers; the datapath consumes only this block's outputs for control.

---
 rtl/pipe_control.sv | 229 ++++++++++++++++++++++
 tb/tb_pipe_control.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_control.sv
// Pipelined control for the mips32 core: ID decode, EX/MEM/WB control and destination registers,
// hazard detection (stall, bubble, flush, memory freeze) and EX operand forwarding selects.
module pipe_control #(
  parameter int unsigned CONTROL_SIZE = 8,
  parameter int unsigned REG_W        = 5,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic [5:0]              opcode,
  input  logic [5:0]              func,
  input  logic [REG_W-1:0]        rs,
  input  logic [REG_W-1:0]        rt,
  input  logic [REG_W-1:0]        rd,
  input  logic                    branch_taken,
  input  logic                    dmem_ready,
  output logic [1:0]              branch_src,
  output logic [1:0]              compare_code,
  output logic [CONTROL_SIZE-1:0] ctrl_ex,
  output logic [CONTROL_SIZE-1:0] ctrl_mem,
  output logic [CONTROL_SIZE-1:0] ctrl_wb,
  output logic [REG_W-1:0]        dest_ex,
  output logic [REG_W-1:0]        dest_mem,
  output logic [REG_W-1:0]        dest_wb,
  output logic [1:0]              fwd_a,
  output logic [1:0]              fwd_b,
  output logic                    pc_write,
  output logic                    ifid_write,
  output logic                    ifid_flush,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        flush_cnt
);

  localparam int unsigned B_MEMREAD  = 4;
  localparam int unsigned B_MEMWRITE = 3;
  localparam int unsigned B_REGWRITE = 2;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [7:0] CW_RTYPE = 8'h84;
  localparam logic [7:0] CW_IMM   = 8'h24;
  localparam logic [7:0] CW_LW    = 8'h35;
  localparam logic [7:0] CW_SW    = 8'h08;
  localparam logic [7:0] CW_JAL   = 8'h46;

  logic [CONTROL_SIZE-1:0] ctrl_id;
  logic [REG_W-1:0]        dest_id;
  logic [1:0]              src_id, cc_id;
  logic                    use_rs, use_rt;

  logic [CONTROL_SIZE-1:0] ctrl_ex_q, ctrl_ex_d, ctrl_mem_q, ctrl_mem_d, ctrl_wb_q, ctrl_wb_d;
  logic [REG_W-1:0]        dest_ex_q, dest_ex_d, dest_mem_q, dest_mem_d, dest_wb_q, dest_wb_d;
  logic [REG_W-1:0]        rs_ex_q, rs_ex_d, rt_ex_q, rt_ex_d;
  logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic ex_match, mem_match, load_use, branch_hazard, freeze, stall, flush;

  // Producer writes a nonzero register equal to the given source register
  function automatic logic writes_reg(input logic [CONTROL_SIZE-1:0] c,
                                      input logic [REG_W-1:0] d,
                                      input logic [REG_W-1:0] r);
    return c[B_REGWRITE] && (d != '0) && (d == r);
  endfunction

  // ID decode
  always_comb begin
    ctrl_id = '0;
    dest_id = '0;
    src_id  = 2'd0;
    cc_id   = 2'd0;
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    if (id_valid) begin
      case (opcode)
        OP_RTYPE: begin
          use_rs = 1'b1;
          if (func == FN_JR) begin
            src_id = 2'd2;
            cc_id  = 2'b11;
          end else begin
            ctrl_id = CONTROL_SIZE'(CW_RTYPE);
            dest_id = rd;
            use_rt  = 1'b1;
          end
        end
        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
          ctrl_id = CONTROL_SIZE'(CW_IMM);
          dest_id = rt;
          use_rs  = 1'b1;
        end
        OP_LW: begin
          ctrl_id = CONTROL_SIZE'(CW_LW);
          dest_id = rt;
          use_rs  = 1'b1;
        end
        OP_SW: begin
          ctrl_id = CONTROL_SIZE'(CW_SW);
          use_rs  = 1'b1;
          use_rt  = 1'b1;
        end
        OP_BEQ, OP_BNE: begin
          cc_id  = (opcode == OP_BEQ) ? 2'b01 : 2'b10;
          use_rs = 1'b1;
          use_rt = 1'b1;
        end
        OP_J: begin
          src_id = 2'd1;
          cc_id  = 2'b11;
        end
        OP_JAL: begin
          ctrl_id = CONTROL_SIZE'(CW_JAL);
          dest_id = REG_W'(31);
          src_id  = 2'd1;
          cc_id   = 2'b11;
        end
        default: ;
      endcase
    end
  end

  // Hazard detection and front-end control
  always_comb begin
    ex_match      = (use_rs && writes_reg(ctrl_ex_q, dest_ex_q, rs)) ||
                    (use_rt && writes_reg(ctrl_ex_q, dest_ex_q, rt));
    mem_match     = (use_rs && writes_reg(ctrl_mem_q, dest_mem_q, rs)) ||
                    (use_rt && writes_reg(ctrl_mem_q, dest_mem_q, rt));
    load_use      = ctrl_ex_q[B_MEMREAD] && ex_match;
    branch_hazard = (cc_id != 2'b00) && (ex_match || (ctrl_mem_q[B_MEMREAD] && mem_match));
    freeze        = (ctrl_mem_q[B_MEMREAD] || ctrl_mem_q[B_MEMWRITE]) && !dmem_ready;
    stall         = !freeze && (load_use || branch_hazard);
    flush         = !freeze && !stall && (cc_id != 2'b00) && branch_taken;
    pc_write      = !(freeze || stall);
    ifid_write    = !(freeze || stall);
    ifid_flush    = flush;
    branch_src    = stall ? 2'd0 : src_id;
    compare_code  = stall ? 2'd0 : cc_id;
  end

  // Stage advance: freeze holds everything, stall injects a bubble into EX
  always_comb begin
    ctrl_ex_d   = ctrl_ex_q;
    dest_ex_d   = dest_ex_q;
    rs_ex_d     = rs_ex_q;
    rt_ex_d     = rt_ex_q;
    ctrl_mem_d  = ctrl_mem_q;
    dest_mem_d  = dest_mem_q;
    ctrl_wb_d   = ctrl_wb_q;
    dest_wb_d   = dest_wb_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!freeze) begin
      ctrl_wb_d  = ctrl_mem_q;
      dest_wb_d  = dest_mem_q;
      ctrl_mem_d = ctrl_ex_q;
      dest_mem_d = dest_ex_q;
      if (stall) begin
        ctrl_ex_d = '0;
        dest_ex_d = '0;
        rs_ex_d   = '0;
        rt_ex_d   = '0;
      end else begin
        ctrl_ex_d = ctrl_id;
        dest_ex_d = dest_id;
        rs_ex_d   = use_rs ? rs : '0;
        rt_ex_d   = use_rt ? rt : '0;
      end
    end
    if (freeze || stall) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush)           flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_ex_q   <= '0;
      dest_ex_q   <= '0;
      rs_ex_q     <= '0;
      rt_ex_q     <= '0;
      ctrl_mem_q  <= '0;
      dest_mem_q  <= '0;
      ctrl_wb_q   <= '0;
      dest_wb_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ctrl_ex_q   <= ctrl_ex_d;
      dest_ex_q   <= dest_ex_d;
      rs_ex_q     <= rs_ex_d;
      rt_ex_q     <= rt_ex_d;
      ctrl_mem_q  <= ctrl_mem_d;
      dest_mem_q  <= dest_mem_d;
      ctrl_wb_q   <= ctrl_wb_d;
      dest_wb_q   <= dest_wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // EX forwarding selects, MEM before WB
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (writes_reg(ctrl_mem_q, dest_mem_q, rs_ex_q))     fwd_a = 2'b01;
    else if (writes_reg(ctrl_wb_q, dest_wb_q, rs_ex_q))  fwd_a = 2'b10;
    if (writes_reg(ctrl_mem_q, dest_mem_q, rt_ex_q))     fwd_b = 2'b01;
    else if (writes_reg(ctrl_wb_q, dest_wb_q, rt_ex_q))  fwd_b = 2'b10;
  end

  assign ctrl_ex   = ctrl_ex_q;
  assign ctrl_mem  = ctrl_mem_q;
  assign ctrl_wb   = ctrl_wb_q;
  assign dest_ex   = dest_ex_q;
  assign dest_mem  = dest_mem_q;
  assign dest_wb   = dest_wb_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control: a vector table streamed through the pipe plus
// hand sequences for memory freeze and reset during a stall.
module tb_pipe_control;

  localparam int unsigned CONTROL_SIZE = 8;
  localparam int unsigned REG_W        = 5;
  localparam int unsigned CNT_W        = 16;
  localparam int unsigned NVEC         = 24;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_ADI = 6'b001000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BAD = 6'b111111;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_JR   = 6'b001000;

  logic                    clock = 1'b0;
  logic                    reset, id_valid, branch_taken, dmem_ready;
  logic [5:0]              opcode, func;
  logic [REG_W-1:0]        rs, rt, rd;
  logic [1:0]              branch_src, compare_code, fwd_a, fwd_b;
  logic [CONTROL_SIZE-1:0] ctrl_ex, ctrl_mem, ctrl_wb;
  logic [REG_W-1:0]        dest_ex, dest_mem, dest_wb;
  logic                    pc_write, ifid_write, ifid_flush;
  logic [CNT_W-1:0]        stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_control #(.CONTROL_SIZE(CONTROL_SIZE), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .opcode(opcode), .func(func),
    .rs(rs), .rt(rt), .rd(rd), .branch_taken(branch_taken), .dmem_ready(dmem_ready),
    .branch_src(branch_src), .compare_code(compare_code),
    .ctrl_ex(ctrl_ex), .ctrl_mem(ctrl_mem), .ctrl_wb(ctrl_wb),
    .dest_ex(dest_ex), .dest_mem(dest_mem), .dest_wb(dest_wb),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       v;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    logic       bt;
    logic [1:0] src, cc;
    logic       pcw, fl;
    logic [7:0] cex, cmem, cwb;
    logic [4:0] dex;
    logic [1:0] fa, fb;
  } vec_t;

  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic v, input logic [5:0] op, input logic [5:0] fn,
                              input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                              input logic bt, input logic [1:0] src, input logic [1:0] cc,
                              input logic pcw, input logic fl, input logic [7:0] cex,
                              input logic [7:0] cmem, input logic [7:0] cwb,
                              input logic [4:0] dex, input logic [1:0] fa, input logic [1:0] fb);
    vec_t r;
    r.v = v; r.op = op; r.fn = fn; r.rs = a; r.rt = b; r.rd = d; r.bt = bt;
    r.src = src; r.cc = cc; r.pcw = pcw; r.fl = fl;
    r.cex = cex; r.cmem = cmem; r.cwb = cwb; r.dex = dex; r.fa = fa; r.fb = fb;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                       input logic bt);
    id_valid = v; opcode = op; func = fn; rs = a; rt = b; rd = d; branch_taken = bt;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // row: v op fn rs rt rd bt | src cc pcw flush | cex cmem cwb dex fa fb
    tbl[0]  = mk(1, OP_R,   F_ADD, 1, 2, 3, 0,  0, 0, 1, 0,  8'h84, 8'h00, 8'h00, 3,  0, 0);
    tbl[1]  = mk(0, OP_R,   F_ADD, 0, 0, 0, 0,  0, 0, 1, 0,  8'h00, 8'h84, 8'h00, 0,  0, 0);
    tbl[2]  = mk(0, OP_R,   F_ADD, 0, 0, 0, 0,  0, 0, 1, 0,  8'h00, 8'h00, 8'h84, 0,  0, 0);
    tbl[3]  = mk(1, OP_LW,  0,     1, 5, 0, 0,  0, 0, 1, 0,  8'h35, 8'h00, 8'h00, 5,  0, 0);
    tbl[4]  = mk(1, OP_R,   F_ADD, 5, 6, 7, 0,  0, 0, 0, 0,  8'h00, 8'h35, 8'h00, 0,  0, 0);
    tbl[5]  = mk(1, OP_R,   F_ADD, 5, 6, 7, 0,  0, 0, 1, 0,  8'h84, 8'h00, 8'h35, 7,  2, 0);
    tbl[6]  = mk(1, OP_R,   F_SUB, 7, 7, 4, 0,  0, 0, 1, 0,  8'h84, 8'h84, 8'h00, 4,  1, 1);
    tbl[7]  = mk(1, OP_R,   F_ADD, 4, 0, 0, 0,  0, 0, 1, 0,  8'h84, 8'h84, 8'h84, 0,  1, 0);
    tbl[8]  = mk(1, OP_R,   F_ADD, 0, 4, 9, 0,  0, 0, 1, 0,  8'h84, 8'h84, 8'h84, 9,  0, 2);
    tbl[9]  = mk(1, OP_BEQ, 0,     2, 2, 0, 1,  0, 1, 1, 1,  8'h00, 8'h84, 8'h84, 0,  0, 0);
    tbl[10] = mk(0, OP_R,   0,     0, 0, 0, 0,  0, 0, 1, 0,  8'h00, 8'h00, 8'h84, 0,  0, 0);
    tbl[11] = mk(1, OP_ADI, 0,     3, 2, 0, 0,  0, 0, 1, 0,  8'h24, 8'h00, 8'h00, 2,  0, 0);
    tbl[12] = mk(1, OP_BNE, 0,     2, 1, 0, 1,  0, 0, 0, 0,  8'h00, 8'h24, 8'h00, 0,  0, 0);
    tbl[13] = mk(1, OP_BNE, 0,     2, 1, 0, 1,  0, 2, 1, 1,  8'h00, 8'h00, 8'h24, 0,  2, 0);
    tbl[14] = mk(1, OP_LW,  0,     0, 2, 0, 0,  0, 0, 1, 0,  8'h35, 8'h00, 8'h00, 2,  0, 0);
    tbl[15] = mk(1, OP_BEQ, 0,     2, 2, 0, 1,  0, 0, 0, 0,  8'h00, 8'h35, 8'h00, 0,  0, 0);
    tbl[16] = mk(1, OP_BEQ, 0,     2, 2, 0, 1,  0, 0, 0, 0,  8'h00, 8'h00, 8'h35, 0,  0, 0);
    tbl[17] = mk(1, OP_BEQ, 0,     2, 2, 0, 1,  0, 1, 1, 1,  8'h00, 8'h00, 8'h00, 0,  0, 0);
    tbl[18] = mk(1, OP_JAL, 0,     0, 0, 0, 1,  1, 3, 1, 1,  8'h46, 8'h00, 8'h00, 31, 0, 0);
    tbl[19] = mk(1, OP_J,   0,     0, 0, 0, 1,  1, 3, 1, 1,  8'h00, 8'h46, 8'h00, 0,  0, 0);
    tbl[20] = mk(1, OP_R,   F_JR,  31, 0, 0, 1, 2, 3, 1, 1,  8'h00, 8'h00, 8'h46, 0,  2, 0);
    tbl[21] = mk(1, OP_BAD, 0,     1, 2, 3, 1,  0, 0, 1, 0,  8'h00, 8'h00, 8'h00, 0,  0, 0);
    tbl[22] = mk(1, OP_SW,  0,     1, 3, 0, 0,  0, 0, 1, 0,  8'h08, 8'h00, 8'h00, 0,  0, 0);
    tbl[23] = mk(0, OP_R,   0,     0, 0, 0, 0,  0, 0, 1, 0,  8'h00, 8'h08, 8'h00, 0,  0, 0);

    reset = 1'b1;
    dmem_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst ctrl_ex",   32'(ctrl_ex), 32'h0);
    chk("rst ctrl_mem",  32'(ctrl_mem), 32'h0);
    chk("rst ctrl_wb",   32'(ctrl_wb), 32'h0);
    chk("rst dest_ex",   32'(dest_ex), 32'h0);
    chk("rst fwd_a",     32'(fwd_a), 32'h0);
    chk("rst fwd_b",     32'(fwd_b), 32'h0);
    chk("rst pc_write",  32'(pc_write), 32'h1);
    chk("rst ifid_wr",   32'(ifid_write), 32'h1);
    chk("rst ifid_fl",   32'(ifid_flush), 32'h0);
    chk("rst stall_cnt", 32'(stall_cnt), 32'h0);
    chk("rst flush_cnt", 32'(flush_cnt), 32'h0);

    for (int i = 0; i < int'(NVEC); i++) begin
      drive(tbl[i].v, tbl[i].op, tbl[i].fn, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].bt);
      #2;
      chk($sformatf("v%0d branch_src", i), 32'(branch_src), 32'(tbl[i].src));
      chk($sformatf("v%0d compare_code", i), 32'(compare_code), 32'(tbl[i].cc));
      chk($sformatf("v%0d pc_write", i), 32'(pc_write), 32'(tbl[i].pcw));
      chk($sformatf("v%0d ifid_write", i), 32'(ifid_write), 32'(tbl[i].pcw));
      chk($sformatf("v%0d ifid_flush", i), 32'(ifid_flush), 32'(tbl[i].fl));
      tick();
      chk($sformatf("v%0d ctrl_ex", i), 32'(ctrl_ex), 32'(tbl[i].cex));
      chk($sformatf("v%0d ctrl_mem", i), 32'(ctrl_mem), 32'(tbl[i].cmem));
      chk($sformatf("v%0d ctrl_wb", i), 32'(ctrl_wb), 32'(tbl[i].cwb));
      chk($sformatf("v%0d dest_ex", i), 32'(dest_ex), 32'(tbl[i].dex));
      chk($sformatf("v%0d fwd_a", i), 32'(fwd_a), 32'(tbl[i].fa));
      chk($sformatf("v%0d fwd_b", i), 32'(fwd_b), 32'(tbl[i].fb));
    end
    chk("table stall_cnt", 32'(stall_cnt), 32'd4);
    chk("table flush_cnt", 32'(flush_cnt), 32'd6);

    // SW sits in MEM; memory not ready for three cycles
    dmem_ready = 1'b0;
    drive(1, OP_R, F_ADD, 1, 2, 10, 0);
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("frz%0d pc_write", c), 32'(pc_write), 32'h0);
      chk($sformatf("frz%0d ifid_write", c), 32'(ifid_write), 32'h0);
      chk($sformatf("frz%0d ifid_flush", c), 32'(ifid_flush), 32'h0);
      tick();
      chk($sformatf("frz%0d ctrl_ex", c), 32'(ctrl_ex), 32'h00);
      chk($sformatf("frz%0d ctrl_mem", c), 32'(ctrl_mem), 32'h08);
      chk($sformatf("frz%0d ctrl_wb", c), 32'(ctrl_wb), 32'h00);
      chk($sformatf("frz%0d dest_ex", c), 32'(dest_ex), 32'h0);
    end
    chk("frz stall_cnt", 32'(stall_cnt), 32'd7);
    dmem_ready = 1'b1;
    #2;
    chk("resume pc_write", 32'(pc_write), 32'h1);
    tick();
    chk("resume ctrl_ex",   32'(ctrl_ex), 32'h84);
    chk("resume dest_ex",   32'(dest_ex), 32'd10);
    chk("resume ctrl_mem",  32'(ctrl_mem), 32'h00);
    chk("resume ctrl_wb",   32'(ctrl_wb), 32'h08);
    chk("resume stall_cnt", 32'(stall_cnt), 32'd7);
    chk("resume flush_cnt", 32'(flush_cnt), 32'd6);

    // Reset during a load-use stall drops everything in flight
    drive(1, OP_LW, 0, 0, 5, 0, 0);
    tick();
    drive(1, OP_R, F_ADD, 5, 0, 6, 0);
    #2;
    chk("midrst stall pc_write", 32'(pc_write), 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("midrst ctrl_ex",   32'(ctrl_ex), 32'h0);
    chk("midrst ctrl_mem",  32'(ctrl_mem), 32'h0);
    chk("midrst ctrl_wb",   32'(ctrl_wb), 32'h0);
    chk("midrst dest_mem",  32'(dest_mem), 32'h0);
    chk("midrst dest_wb",   32'(dest_wb), 32'h0);
    chk("midrst pc_write",  32'(pc_write), 32'h1);
    chk("midrst stall_cnt", 32'(stall_cnt), 32'h0);
    chk("midrst flush_cnt", 32'(flush_cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
